// File: rtl/mac_pkg.sv
// Shared types and helpers for the FC-layer MAC feeder: FSM states, lane geometry,
// the tail-word lane mask and int8 saturation.
package mac_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int RES_W  = 26;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_BIAS,
    S_CAPTURE,
    S_FLUSH,
    S_FIN
  } state_t;

  // A length that is a multiple of the lane count fills the whole last word.
  function automatic logic [LANES-1:0] tail_mask(input logic [1:0] len_lo);
    return (len_lo == 2'd0) ? {LANES{1'b1}} : LANES'((1 << len_lo) - 1);
  endfunction

  function automatic logic [LANE_W-1:0] sat8(input logic signed [31:0] v);
    if (v > 32'sd127)
      return 8'h7f;
    else if (v < -32'sd128)
      return 8'h80;
    else
      return v[LANE_W-1:0];
  endfunction

endpackage

// File: rtl/mac_feeder_if.sv
// Feeder <-> mac_controller bundle; the feeder is master, the controller is slave.
// Purely wiring: no latency, no backpressure (the controller always accepts).
interface mac_feeder_if;
  import mac_pkg::*;

  logic                      en;
  logic [LANES-1:0]          valid;
  logic [LANES*LANE_W-1:0]   feature;
  logic [LANES*LANE_W-1:0]   weight;
  logic [LANE_W-1:0]         bias;
  logic                      bias_add;
  logic                      flush;
  logic [RES_W-1:0]          result;
  logic                      done;

  modport master (output en, valid, feature, weight, bias, bias_add, flush,
                  input  result, done);
  modport slave  (input  en, valid, feature, weight, bias, bias_add, flush,
                  output result, done);

endinterface

// File: rtl/mac_feeder_requant.sv
// Combinational requantizer: arithmetic shift, int8 saturation, zero latency, no backpressure.
// Build option MAC_FEEDER_RELU_EN forces negative outputs to zero.
module mac_feeder_requant
  import mac_pkg::*;
#(
  parameter int SHIFT = 7
) (
  input  logic signed [RES_W-1:0] result,
  output logic [LANE_W-1:0]       q
);

  logic signed [RES_W-1:0] shifted;
  logic [LANE_W-1:0]       q_sat;

  assign shifted = result >>> SHIFT;
  assign q_sat   = sat8({{(32-RES_W){shifted[RES_W-1]}}, shifted});

`ifdef MAC_FEEDER_RELU_EN
  assign q = q_sat[LANE_W-1] ? '0 : q_sat;
`else
  assign q = q_sat;
`endif

endmodule

// File: rtl/mac_feeder.sv
// Sequences one FC layer into mac_controller: stream words, drain, bias, capture, flush, emit int8.
// One address pair per cycle, data aligned 1 cycle later; no backpressure. Option: MAC_FEEDER_RELU_EN.
module mac_feeder
  import mac_pkg::*;
#(
  parameter int FADDR_W  = 8,
  parameter int WADDR_W  = 14,
  parameter int NEURON_W = 6,
  parameter int LEN_W    = 10,
  parameter int MAC_LAT  = 2,
  parameter int SHIFT    = 7
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [LEN_W-1:0]    in_len,
  input  logic [NEURON_W-1:0] n_neurons,
  output logic [FADDR_W-1:0]  feat_addr,
  input  logic [31:0]         feat_rdata,
  output logic [WADDR_W-1:0]  wgt_addr,
  input  logic [31:0]         wgt_rdata,
  output logic [NEURON_W-1:0] bias_addr,
  input  logic [7:0]          bias_rdata,
  mac_feeder_if.master        mac,
  output logic                out_valid,
  output logic [7:0]          out_data,
  output logic [NEURON_W-1:0] out_idx,
  output logic                busy,
  output logic                done_all
);

  localparam int WRD_W = LEN_W - 1;
  localparam int DRN_W = $clog2(MAC_LAT + 2);

  state_t                  state, state_nxt;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W:0]          len_p3;
  logic [WRD_W-1:0]        words, word_cnt;
  logic [NEURON_W-1:0]     nn_q, neuron_cnt;
  logic [WADDR_W-1:0]      wgt_cnt;
  logic [DRN_W-1:0]        drain_cnt;
  logic [LANES-1:0]        vld_q;
  logic signed [RES_W-1:0] res_q;
  logic [LANE_W-1:0]       q_dat;
  logic                    last_word, drain_done, last_neuron;

  assign len_p3      = {1'b0, len_q} + (LEN_W+1)'(3);
  assign words       = WRD_W'(len_p3 >> 2);
  assign last_word   = (word_cnt == words - WRD_W'(1));
  assign drain_done  = (drain_cnt == DRN_W'(MAC_LAT));
  assign last_neuron = (neuron_cnt == nn_q - NEURON_W'(1));

  assign feat_addr   = FADDR_W'(word_cnt);
  assign wgt_addr    = wgt_cnt;
  assign bias_addr   = neuron_cnt;

  // Sync-read data arrives one cycle after its address, alongside the registered lane mask.
  assign mac.valid   = vld_q;
  assign mac.feature = (|vld_q) ? feat_rdata : '0;
  assign mac.weight  = (|vld_q) ? wgt_rdata  : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    busy         = 1'b0;
    done_all     = 1'b0;
    mac.en       = 1'b0;
    mac.bias_add = 1'b0;
    mac.bias     = '0;
    mac.flush    = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_idx      = '0;
    case (state)
      S_IDLE: begin
        if (start)
          state_nxt = (n_neurons == '0) ? S_FIN : (in_len == '0) ? S_DRAIN : S_STREAM;
      end
      S_STREAM:  if (last_word)  state_nxt = S_DRAIN;
      S_DRAIN:   if (drain_done) state_nxt = S_BIAS;
      S_BIAS: begin
        state_nxt    = S_CAPTURE;
        mac.bias_add = 1'b1;
        mac.bias     = bias_rdata;
      end
      S_CAPTURE: if (mac.done)   state_nxt = S_FLUSH;
      S_FLUSH: begin
        state_nxt = last_neuron ? S_FIN : (len_q == '0) ? S_DRAIN : S_STREAM;
        mac.flush = 1'b1;
        out_valid = 1'b1;
        out_data  = q_dat;
        out_idx   = neuron_cnt;
      end
      S_FIN: begin
        state_nxt = S_IDLE;
        done_all  = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state != S_IDLE && state != S_FIN) begin
      busy   = 1'b1;
      mac.en = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q      <= '0;
      nn_q       <= '0;
      neuron_cnt <= '0;
      word_cnt   <= '0;
      wgt_cnt    <= '0;
      drain_cnt  <= '0;
      vld_q      <= '0;
      res_q      <= '0;
    end else begin
      vld_q <= (state == S_STREAM) ? (last_word ? tail_mask(len_q[1:0]) : {LANES{1'b1}}) : '0;
      case (state)
        S_IDLE: if (start) begin
          len_q      <= in_len;
          nn_q       <= n_neurons;
          neuron_cnt <= '0;
          word_cnt   <= '0;
          wgt_cnt    <= '0;
        end
        S_STREAM: begin
          word_cnt <= last_word ? '0 : word_cnt + WRD_W'(1);
          wgt_cnt  <= wgt_cnt + WADDR_W'(1);
        end
        S_DRAIN:   drain_cnt <= drain_done ? '0 : drain_cnt + DRN_W'(1);
        S_CAPTURE: if (mac.done) res_q <= mac.result;
        S_FLUSH:   neuron_cnt <= neuron_cnt + NEURON_W'(1);
        S_FIN: begin
          neuron_cnt <= '0;
          wgt_cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

  mac_feeder_requant #(.SHIFT(SHIFT)) u_requant (
    .result (res_q),
    .q      (q_dat)
  );

endmodule
